cmd_serializer: RTL
===================

# cmd_serializer

Parallel-to-serial transmitter for the SD host CMD line, the transmit-side counterpart of the command/response deserializer. It takes a parallel command word, shifts it out MSB-first one bit per enabled clock, and can append a CRC7 and end bit. It drives the line-enable for the CMD tri-state buffer and reports completion with a one-cycle `complete` pulse. It sits between the command FSM and the CMD pad.

## Interface

- `BITS`, 48, width of the parallel input word.
- `BITS_COUNTER`, 8, width of the bit counter; at least log2(BITS)+1.
- `clk` in 1: serial bit clock (SD clock domain); all state changes on rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-high.
- `enable` in 1: low freezes all state and outputs (clock-suspend).
- `start` in 1: request to send; sampled on enabled edges in IDLE only.
- `framesize` in BITS_COUNTER: number of data bits to send minus 1; latched at start.
- `append_crc` in 1: 1 = append CRC7 plus end bit '1' after data; latched at start.
- `in` in BITS: data word; bit `framesize` sent first, bit 0 last; latched at start.
- `out` out 1: serial data; idles high.
- `out_en` out 1: high while a frame bit is driven.
- `busy` out 1: high from start acceptance until return to IDLE.
- `complete` out 1: high while in DONE.

## Operation

- States: IDLE, DATA, CRC, END, DONE.
- Reset (async, any state): state IDLE; `out`=1, `out_en`=0, `busy`=0, `complete`=0; counter, shift register and CRC register cleared.
- IDLE: `out`=1, `out_en`=0. On an edge with `enable`=1 and `start`=1: latch `in`, `framesize` and `append_crc`. Clamp `framesize` ≥ BITS to BITS-1. Set counter = framesize, clear CRC to 0, go to DATA, drive bit `in[framesize]`.
- DATA: each enabled edge updates CRC with the bit just driven (fb = crc[6]^bit; crc = {crc[5:0],0} ^ (fb ? 7'h09 : 0)), which is polynomial x^7+x^3+1.
  - If counter ≠ 0: decrement counter and drive the next lower bit.
  - If counter = 0 and `append_crc`=1: go to CRC, counter=6, drive the updated crc[6].
  - If counter = 0 and `append_crc`=0: go to DONE.
- CRC: drive crc[counter] bits, MSB first. When counter = 0, go to END.
- END: drive '1' for one cycle, then go to DONE.
- DONE: `out`=1, `out_en`=0, `complete`=1, `busy`=1. On the next enabled edge go to IDLE. `start` is ignored in DONE.
- `start` during DATA, CRC or END is ignored; the latched frame is not disturbed.
- `enable`=0 in any state: hold state, counter, CRC, `out`, `out_en`, `busy` and `complete`. `start` is ignored.
- `in`, `framesize` and `append_crc` may change freely after the acceptance edge.

## Timing

- Acceptance edge E0: the first bit is on `out` and `out_en`=1 after E0. Zero extra latency.
- N = framesize+1 (+8 if `append_crc`). Bits occupy the N enabled cycles following E0.
- After enabled edge E_N: DONE, so `complete`=1, `out_en`=0, `out`=1.
- After E_(N+1): IDLE, so `complete`=0 and `busy`=0. The earliest next acceptance is E_(N+2).
- `complete` is exactly one cycle wide when `enable` stays high. It stretches across disabled cycles.
- Edge case framesize=0 without CRC: one bit is driven, then DONE.
- Reset mid-frame: outputs return to idle values asynchronously. No `complete` is produced.

## Test plan

- CMD0: `in`=40'h4000000000, framesize=39, append_crc=1. `out` must be 48'h400000000095 MSB-first over 48 cycles, with `out_en` high exactly those cycles and `complete` high one cycle after.
- CMD8: `in`=40'h48000001AA, CRC on. Stream must be 48'h48000001AA87. Repeat with CMD17 arg 0: 40'h5100000000 → 48'h510000000055.
- Raw mode: `in`=8'hA5 (low bits), framesize=7, append_crc=0. Stream must be 1,0,1,0,0,1,0,1, then DONE. Total 8 driven cycles.
- Suspend: during CMD0, drop `enable` for 5 cycles at bit 20. `out` and `out_en` must hold, the stream must resume unchanged and still equal 48'h400000000095, and `complete` must be delayed by 5 cycles.
- Interference: pulse `start` with a different `in` mid-frame and during DONE. The frame must be unchanged, and the new start must be ignored until IDLE.
- Reset: assert `reset` at bit 10. `out`=1, `out_en`=0, `busy`=0 immediately, with no `complete`. A fresh CMD0 after reset must yield 48'h400000000095.

Source files
------------

// File: rtl/cmd_serializer.sv
// SD CMD-line transmitter: shifts a latched command word out MSB-first,
// optionally followed by CRC7 and the end bit, under clock-enable control.
module cmd_serializer #(
  parameter int BITS         = 48,
  parameter int BITS_COUNTER = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    start,
  input  logic [BITS_COUNTER-1:0] framesize,
  input  logic                    append_crc,
  input  logic [BITS-1:0]         in,
  output logic                    out,
  output logic                    out_en,
  output logic                    busy,
  output logic                    complete
);
  typedef enum logic [2:0] {IDLE, DATA, CRC, END, DONE} state_t;

  localparam logic [BITS_COUNTER-1:0] MAX_FS = BITS_COUNTER'(BITS - 1);
  localparam logic [BITS_COUNTER-1:0] ONE    = BITS_COUNTER'(1);
  localparam logic [BITS_COUNTER-1:0] SIX    = BITS_COUNTER'(6);

  state_t                  state, state_n;
  logic [BITS_COUNTER-1:0] cnt, cnt_n, fs_c;
  logic [BITS-1:0]         shreg, shreg_n;
  logic [6:0]              crc, crc_n, crc_upd;
  logic                    crc_on, crc_on_n;

  // The word is pre-aligned so the bit being driven is always shreg MSB;
  // likewise the CRC register shifts so the driven CRC bit is crc[6].
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shreg_n  = shreg;
    crc_n    = crc;
    crc_on_n = crc_on;
    fs_c     = (framesize > MAX_FS) ? MAX_FS : framesize;
    crc_upd  = {crc[5:0], 1'b0} ^ ((crc[6] ^ shreg[BITS-1]) ? 7'h09 : 7'h00);
    case (state)
      IDLE: if (start) begin
        shreg_n  = in << (MAX_FS - fs_c);
        cnt_n    = fs_c;
        crc_n    = '0;
        crc_on_n = append_crc;
        state_n  = DATA;
      end
      DATA: begin
        crc_n   = crc_upd;
        shreg_n = shreg << 1;
        if (cnt != '0) cnt_n = cnt - ONE;
        else if (crc_on) begin
          cnt_n   = SIX;
          state_n = CRC;
        end else state_n = DONE;
      end
      CRC: begin
        crc_n = {crc[5:0], 1'b0};
        if (cnt != '0) cnt_n = cnt - ONE;
        else state_n = END;
      end
      END:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      shreg  <= '0;
      crc    <= '0;
      crc_on <= 1'b0;
    end else if (enable) begin
      state  <= state_n;
      cnt    <= cnt_n;
      shreg  <= shreg_n;
      crc    <= crc_n;
      crc_on <= crc_on_n;
    end
  end

  always_comb begin
    out      = 1'b1;
    out_en   = 1'b0;
    busy     = (state != IDLE);
    complete = (state == DONE);
    case (state)
      DATA:    begin out = shreg[BITS-1]; out_en = 1'b1; end
      CRC:     begin out = crc[6];        out_en = 1'b1; end
      END:     out_en = 1'b1;
      default: ;
    endcase
  end
endmodule
